data_sram_responder: RTL and testbench

//  Responder end of the EX-stage data request bus {req,we,size,wstrb,addr[11:0],wdata}.
//  - Accepts requests with a one-cycle addr_ok handshake.
//  - Serves loads from a local synchronous data RAM, returning data_ok one cycle after acceptance.
//  - Parks stores in a small in-order store buffer until the WB stage commits them or an exception flush discards them.
//  - Sits on the D-side between EX (issue) and WB (commit).

---
 rtl/data_sram_responder_pkg.sv | 20 ++
 rtl/data_sram_responder_store_buffer_fifo.sv | 82 ++++++++
 rtl/data_sram_responder.sv | 94 +++++++++
 tb/tb_data_sram_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared widths, size encodings and entry types for the data SRAM responder
package data_sram_responder_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned IDX_MAX_W = 10;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [DATA_W-1:0] word_t;

  function automatic logic strb_overlap(input strb_t a, input strb_t b);
    return |(a & b);
  endfunction

endpackage

// File: rtl/data_sram_responder_store_buffer_fifo.sv
// rtl/data_sram_responder_store_buffer_fifo.sv - in-order store buffer with flush and index+strobe match vector
module store_buffer_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 10,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  strb_t            push_strb,
  input  word_t            push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [IDX_W-1:0] head_idx,
  output strb_t            head_strb,
  output word_t            head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  input  logic [IDX_W-1:0] match_idx,
  input  strb_t            match_strb,
  output logic             match_hit
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    strb_t            strb;
    word_t            data;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [DEPTH-1:0] match_vec;

  assign head_idx  = ent[head].idx;
  assign head_strb = ent[head].strb;
  assign head_data = ent[head].data;
  assign full      = (count == CNT_W'(DEPTH));
  assign match_hit = |match_vec;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = ({1'b0, PTR_W'(i) - head} < count) &&
                     (ent[i].idx == match_idx) &&
                     strb_overlap(ent[i].strb, match_strb);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent[tail] <= '{idx: push_idx, strb: push_strb, data: push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (flush) begin
        tail  <= pop ? head + PTR_W'(1) : head;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - D-side request responder: accept logic, byte-masked data RAM, load return
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned IDX_W    = 10,
  localparam int unsigned CNT_W   = $clog2(SB_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [1:0]       size_i,
  input  logic [3:0]       wstrb_i,
  input  logic [11:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             addr_ok_o,
  output logic             data_ok_o,
  output logic [31:0]      rdata_o,
  input  logic             sb_commit_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] sb_count_o,
  output logic             sb_full_o
);

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] head_idx;
  strb_t            head_strb;
  word_t            head_data;
  logic             raw_hit;
  logic             st_ok;
  logic             push;
  logic             pop;
  logic             ld_acc;
  logic             unused_bits;
  word_t            mem [0:(1 << IDX_W) - 1];

  assign idx         = addr_i[IDX_W+1:2];
  assign unused_bits = ^{size_i, addr_i};

  // A same-cycle commit frees a full slot, but never releases a RAW hold.
  assign pop       = sb_commit_i & (sb_count_o != '0);
  assign st_ok     = ~sb_full_o | sb_commit_i;
  assign addr_ok_o = req_i & ~flush_i & (we_i ? st_ok : ~raw_hit);
  assign push      = addr_ok_o & we_i;
  assign ld_acc    = addr_ok_o & ~we_i;

  store_buffer_fifo #(
    .DEPTH (SB_DEPTH),
    .IDX_W (IDX_W)
  ) u_sbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_idx   (idx),
    .push_strb  (wstrb_i),
    .push_data  (wdata_i),
    .pop        (pop),
    .flush      (flush_i),
    .head_idx   (head_idx),
    .head_strb  (head_strb),
    .head_data  (head_data),
    .count      (sb_count_o),
    .full       (sb_full_o),
    .match_idx  (idx),
    .match_strb (wstrb_i),
    .match_hit  (raw_hit)
  );

  always_ff @(posedge clk) begin
    if (pop && !rst) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (head_strb[b]) begin
          mem[head_idx][8*b +: 8] <= head_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_ok_o <= 1'b0;
      rdata_o   <= '0;
    end else begin
      data_ok_o <= ld_acc;
      if (ld_acc) begin
        rdata_o <= mem[idx];
      end
    end
  end

  commit_on_empty: assert property (@(posedge clk) disable iff (rst) sb_commit_i |-> sb_count_o != '0);

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - directed self-checking bench for data_sram_responder
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        commit;
  logic        flush;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [2:0]  count;
  logic        full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.SB_DEPTH(4), .IDX_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .size_i      (size),
    .wstrb_i     (wstrb),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .addr_ok_o   (addr_ok),
    .data_ok_o   (data_ok),
    .rdata_o     (rdata),
    .sb_commit_i (commit),
    .flush_i     (flush),
    .sb_count_o  (count),
    .sb_full_o   (full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req = 0; we = 0; commit = 0; flush = 0;
    size = 2'd2; wstrb = 4'h0; addr = 12'h0; wdata = 32'h0;
  endtask

  task automatic drive(input logic w, input logic [11:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic c);
    req = 1; we = w; addr = a; wstrb = s; wdata = d; commit = c; flush = 0; size = 2'd2;
  endtask

  task automatic store(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic c, input logic exp_ok, input string tag);
    drive(1'b1, a, s, d, c);
    #1 chk(tag, addr_ok, exp_ok);
    tick;
    idle;
  endtask

  task automatic commit_only;
    idle;
    commit = 1;
    tick;
    idle;
  endtask

  task automatic load(input logic [11:0] a, input logic [31:0] exp, input string tag);
    drive(1'b0, a, 4'hf, 32'h0, 1'b0);
    #1 chk({tag, "_aok"}, addr_ok, 1);
    tick;
    chk({tag, "_dok"}, data_ok, 1);
    chk({tag, "_rdata"}, rdata, exp);
    idle;
  endtask

  logic [11:0] b2b_addr [8];
  logic [31:0] b2b_data [8];

  initial begin
    idle;
    rst = 1;
    tick;
    tick;
    rst = 0;
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);

    // 1: store, commit, load back
    store(12'h010, 4'hf, 32'h11223344, 0, 1, "t1_st");
    chk("t1_count1", count, 1);
    commit_only;
    chk("t1_count0", count, 0);
    load(12'h010, 32'h11223344, "t1_ld");

    // 2: RAW hold on an overlapping byte store
    store(12'h020, 4'hf, 32'h55667788, 0, 1, "t2_pre");
    commit_only;
    store(12'h021, 4'b0010, 32'hAAAAAAAA, 0, 1, "t2_st");
    drive(1'b0, 12'h020, 4'hf, 32'h0, 1'b0);
    #1 chk("t2_hold", addr_ok, 0);
    tick;
    commit = 1;
    #1 chk("t2_hold_commit", addr_ok, 0);
    tick;
    commit = 0;
    #1 chk("t2_acc", addr_ok, 1);
    tick;
    chk("t2_dok", data_ok, 1);
    chk("t2_rdata", rdata, 32'h5566AA88);
    idle;

    // 3: fill, store+commit at full, store at full without commit
    for (int i = 0; i < 4; i++) store(12'h100 + 12'(4 * i), 4'hf, 32'hD0000000 | i, 0, 1, "t3_fill");
    chk("t3_full", full, 1);
    chk("t3_count4", count, 4);
    store(12'h110, 4'hf, 32'hD0000004, 1, 1, "t3_st_commit");
    chk("t3_count_stay", count, 4);
    store(12'h114, 4'hf, 32'hD0000005, 0, 0, "t3_st_blocked");
    chk("t3_count_blocked", count, 4);
    for (int i = 0; i < 4; i++) commit_only;
    chk("t3_drained", count, 0);
    chk("t3_not_full", full, 0);

    // 4: flush together with commit keeps only the head store
    for (int i = 0; i < 3; i++) store(12'h200 + 12'(4 * i), 4'hf, 32'h01000000 | i, 0, 1, "t4_pre");
    for (int i = 0; i < 3; i++) commit_only;
    for (int i = 0; i < 3; i++) store(12'h200 + 12'(4 * i), 4'hf, 32'hE0000000 | i, 0, 1, "t4_st");
    drive(1'b1, 12'h20C, 4'hf, 32'h99, 1'b1);
    flush = 1;
    #1 chk("t4_flush_no_acc", addr_ok, 0);
    tick;
    idle;
    chk("t4_count0", count, 0);
    load(12'h200, 32'hE0000000, "t4_ld0");
    load(12'h204, 32'h01000001, "t4_ld1");
    load(12'h208, 32'h01000002, "t4_ld2");

    // 5: eight back-to-back loads
    b2b_addr = '{12'h010, 12'h020, 12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'h200};
    b2b_data = '{32'h11223344, 32'h5566AA88, 32'hD0000000, 32'hD0000001,
                 32'hD0000002, 32'hD0000003, 32'hD0000004, 32'hE0000000};
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("t5_dok", data_ok, 1);
        chk("t5_rdata", rdata, b2b_data[i-1]);
      end
      if (i < 8) begin
        drive(1'b0, b2b_addr[i], 4'hf, 32'h0, 1'b0);
        #1 chk("t5_aok", addr_ok, 1);
      end else begin
        idle;
      end
      tick;
    end
    chk("t5_dok_end", data_ok, 0);

    // 6: interleaved push/commit across pointer wrap, then reset mid-stream
    store(12'h300, 4'hf, 32'hA0000000, 0, 1, "t6_st");
    for (int i = 1; i < 6; i++) store(12'h300 + 12'(4 * i), 4'hf, 32'hA0000000 | i, 1, 1, "t6_st_c");
    chk("t6_count1", count, 1);
    commit_only;
    chk("t6_count0", count, 0);
    for (int i = 0; i < 6; i++) load(12'h300 + 12'(4 * i), 32'hA0000000 | i, "t6_ld");

    store(12'h400, 4'hf, 32'hBBBB0000, 0, 1, "t6_rst_st0");
    store(12'h404, 4'hf, 32'hBBBB0001, 0, 1, "t6_rst_st1");
    drive(1'b0, 12'h300, 4'hf, 32'h0, 1'b0);
    rst = 1;
    tick;
    chk("t6_rst_dok", data_ok, 0);
    chk("t6_rst_count", count, 0);
    rst = 0;
    idle;
    tick;
    chk("t6_post_rst_dok", data_ok, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
